frame_buffer_arbiter: RTL and testbench

Schedules the single SDRAM burst port shared by the two frame-difference streams: write bursts that store the current frame's gray pixels, and read bursts that fetch the previous frame into the read FIFO. It sits between the write/read FIFOs that feed the gray-shift stage and the SDRAM controller command port. It also runs ping-pong frame banks: the bank being written this frame becomes the bank read next frame. Frame sequencing is driven by the camera vsync.

---
 rtl/frame_buffer_arbiter.sv | 100 ++++++++++
 tb/tb_frame_buffer_arbiter.sv | 139 +++++++++++++
 2 files changed

// File: rtl/frame_buffer_arbiter.sv
// frame_buffer_arbiter: round-robin write/read burst scheduler for ping-pong frame banks on one SDRAM port.
// Define ARB_URGENT_WRITE_EN to let a nearly full write FIFO override round-robin.
module frame_buffer_arbiter #(
  parameter int                BURST_LEN     = 16,
  parameter int                FRAME_WORDS   = 307200,
  parameter int                ADDR_W        = 24,
  parameter logic [ADDR_W-1:0] BANK_OFFSET   = 24'h080000,
  parameter int                FIFO_AW       = 10,
  parameter int                URGENT_MARGIN = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              frame_vsync,
  input  logic [FIFO_AW:0]  wr_fifo_usedw,
  input  logic [FIFO_AW:0]  rd_fifo_usedw,
  output logic              cmd_req,
  output logic              cmd_wr,
  output logic [ADDR_W-1:0] cmd_addr,
  output logic [7:0]        cmd_len,
  input  logic              cmd_ack,
  input  logic              cmd_done,
  output logic              rd_fifo_clr,
  output logic              prev_valid,
  output logic              frame_incomplete
);
  localparam int CW = $clog2(FRAME_WORDS + 1);
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [CW-1:0] FW = CW'(FRAME_WORDS);
  localparam logic [CW-1:0] BL = CW'(BURST_LEN);
`ifdef ARB_URGENT_WRITE_EN
  localparam bit URGENT_EN = 1'b1;
`else
  localparam bit URGENT_EN = 1'b0;
`endif
  typedef enum logic [1:0] {IDLE, REQ, BUSY, SWAP} state_t;
  state_t state, state_nxt;
  logic vs_q, start_pend, wr_bank, last_grant, wr_ok, rd_ok, urgent, grant_wr;
  logic [CW-1:0] wr_cnt, rd_cnt;
  logic [ADDR_W-1:0] wr_base, rd_base;
  function automatic logic [CW-1:0] sat_add(input logic [CW-1:0] c);
    return (c >= FW - BL) ? FW : c + BL;
  endfunction
  assign cmd_len = 8'(BURST_LEN);
  assign wr_base = wr_bank ? BANK_OFFSET : '0;
  assign rd_base = wr_bank ? '0 : BANK_OFFSET;
  // last_grant: 1 = write, 0 = read; a tie goes to the opposite direction
  always_comb begin
    wr_ok = 32'(wr_fifo_usedw) >= BURST_LEN && wr_cnt < FW;
    rd_ok = prev_valid && rd_cnt < FW && 32'(rd_fifo_usedw) + BURST_LEN <= DEPTH;
    urgent = URGENT_EN && wr_ok && 32'(wr_fifo_usedw) >= DEPTH - URGENT_MARGIN;
    grant_wr = wr_ok && (!rd_ok || !last_grant || urgent);
    cmd_req = state == REQ;
    rd_fifo_clr = state == SWAP;
    state_nxt = state;
    case (state)
      IDLE: state_nxt = start_pend ? SWAP : (wr_ok || rd_ok) ? REQ : IDLE;
      REQ:  state_nxt = cmd_ack ? BUSY : REQ;
      BUSY: state_nxt = cmd_done ? (start_pend ? SWAP : IDLE) : BUSY;
      SWAP: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= state_nxt;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vs_q <= 1'b0;
      start_pend <= 1'b0;
      wr_bank <= 1'b0;
      last_grant <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
      cmd_wr <= 1'b0;
      cmd_addr <= '0;
      prev_valid <= 1'b0;
      frame_incomplete <= 1'b0;
    end else begin
      vs_q <= frame_vsync;
      start_pend <= (frame_vsync & ~vs_q) | (start_pend & (state != SWAP));
      if (state == IDLE && state_nxt == REQ) begin
        cmd_wr <= grant_wr;
        cmd_addr <= grant_wr ? wr_base + ADDR_W'(wr_cnt) : rd_base + ADDR_W'(rd_cnt);
      end
      if (state == BUSY && cmd_done) begin
        last_grant <= cmd_wr;
        if (cmd_wr) wr_cnt <= sat_add(wr_cnt);
        else rd_cnt <= sat_add(rd_cnt);
      end
      if (state == SWAP) begin
        wr_cnt <= '0;
        rd_cnt <= '0;
        if (wr_cnt == FW) begin
          wr_bank <= ~wr_bank;
          prev_valid <= 1'b1;
        end else frame_incomplete <= 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// tb_frame_buffer_arbiter: directed bench for frame_buffer_arbiter with a small SDRAM controller handshake model.
module tb_frame_buffer_arbiter;
  logic clk = 1'b0, rst_n = 1'b0, frame_vsync = 1'b0, cmd_ack = 1'b0, cmd_done = 1'b0;
  logic [4:0] wr_usedw = '0, rd_usedw = '0;
  logic cmd_req, cmd_wr, rd_fifo_clr, prev_valid, frame_incomplete;
  logic [23:0] cmd_addr;
  logic [7:0] cmd_len;
  int total = 0, bad = 0;
  frame_buffer_arbiter #(
    .BURST_LEN(4), .FRAME_WORDS(16), .ADDR_W(24), .BANK_OFFSET(24'h100),
    .FIFO_AW(4), .URGENT_MARGIN(4)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_vsync(frame_vsync),
    .wr_fifo_usedw(wr_usedw), .rd_fifo_usedw(rd_usedw),
    .cmd_req(cmd_req), .cmd_wr(cmd_wr), .cmd_addr(cmd_addr), .cmd_len(cmd_len),
    .cmd_ack(cmd_ack), .cmd_done(cmd_done),
    .rd_fifo_clr(rd_fifo_clr), .prev_valid(prev_valid), .frame_incomplete(frame_incomplete)
  );
  always #5 clk = ~clk;
  task automatic tick();
    @(negedge clk);
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic chk_reset_outs(input string tag);
    chk({tag, "_req"}, 32'(cmd_req), 0);
    chk({tag, "_wr"}, 32'(cmd_wr), 0);
    chk({tag, "_addr"}, 32'(cmd_addr), 0);
    chk({tag, "_len"}, 32'(cmd_len), 4);
    chk({tag, "_clr"}, 32'(rd_fifo_clr), 0);
    chk({tag, "_pv"}, 32'(prev_valid), 0);
    chk({tag, "_fi"}, 32'(frame_incomplete), 0);
  endtask
  task automatic burst(input logic ew, input logic [23:0] ea, input int ack_dly, input bit inj, input bit vs_mid);
    int n = 0;
    while (!cmd_req && n < 30) begin
      tick();
      n++;
    end
    chk("req_seen", 32'(cmd_req), 1);
    if (!cmd_req) return;
    chk("cmd_wr", 32'(cmd_wr), 32'(ew));
    chk("cmd_addr", 32'(cmd_addr), 32'(ea));
    chk("cmd_len", 32'(cmd_len), 4);
    for (int i = 0; i < ack_dly; i++) begin
      tick();
      chk("hold_req", 32'(cmd_req), 1);
      chk("hold_wr", 32'(cmd_wr), 32'(ew));
      chk("hold_addr", 32'(cmd_addr), 32'(ea));
      cmd_done = inj && i == 0;
    end
    cmd_done = 1'b0;
    cmd_ack = 1'b1;
    tick();
    cmd_ack = 1'b0;
    chk("req_drop", 32'(cmd_req), 0);
    for (int i = 0; i < 5; i++) begin
      if (vs_mid) frame_vsync = (i < 2);
      tick();
    end
    frame_vsync = 1'b0;
    cmd_done = 1'b1;
    tick();
    cmd_done = 1'b0;
    chk("done_gap", 32'(cmd_req), 0);
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int n;
    repeat (2) tick();
    chk_reset_outs("rst");
    rst_n = 1'b1;
    tick();
    wr_usedw = 5'd8;
    burst(1'b1, 24'h000, 2, 1'b0, 1'b0);
    burst(1'b1, 24'h004, 2, 1'b0, 1'b0);
    burst(1'b1, 24'h008, 2, 1'b0, 1'b0);
    burst(1'b1, 24'h00C, 2, 1'b0, 1'b0);
    repeat (4) tick();
    chk("f1_no_read", 32'(cmd_req), 0);
    chk("f1_pv", 32'(prev_valid), 0);
    frame_vsync = 1'b1;
    tick();
    chk("vs_clr_n1", 32'(rd_fifo_clr), 0);
    tick();
    chk("vs_clr_n2", 32'(rd_fifo_clr), 1);
    frame_vsync = 1'b0;
    tick();
    chk("vs_clr_n3", 32'(rd_fifo_clr), 0);
    chk("vs_pv", 32'(prev_valid), 1);
    chk("vs_fi", 32'(frame_incomplete), 0);
    burst(1'b0, 24'h000, 2, 1'b0, 1'b0);
    burst(1'b1, 24'h100, 2, 1'b0, 1'b0);
    burst(1'b0, 24'h004, 2, 1'b0, 1'b0);
    burst(1'b1, 24'h104, 2, 1'b0, 1'b0);
    burst(1'b0, 24'h008, 10, 1'b1, 1'b0);
    burst(1'b1, 24'h108, 2, 1'b0, 1'b1);
    chk("mid_clr1", 32'(rd_fifo_clr), 1);
    tick();
    chk("mid_clr2", 32'(rd_fifo_clr), 0);
    chk("mid_fi", 32'(frame_incomplete), 1);
    chk("mid_pv", 32'(prev_valid), 1);
    burst(1'b0, 24'h000, 2, 1'b0, 1'b0);
    burst(1'b1, 24'h100, 2, 1'b0, 1'b0);
    wr_usedw = 5'd12;
`ifdef ARB_URGENT_WRITE_EN
    burst(1'b1, 24'h104, 2, 1'b0, 1'b0);
    burst(1'b1, 24'h108, 2, 1'b0, 1'b0);
`else
    burst(1'b0, 24'h004, 2, 1'b0, 1'b0);
    burst(1'b1, 24'h104, 2, 1'b0, 1'b0);
`endif
    wr_usedw = 5'd8;
    n = 0;
    while (!cmd_req && n < 30) begin
      tick();
      n++;
    end
    chk("rq_before_rst", 32'(cmd_req), 1);
    rst_n = 1'b0;
    #1;
    chk_reset_outs("async_rst");
    tick();
    tick();
    rst_n = 1'b1;
    burst(1'b1, 24'h000, 2, 1'b0, 1'b0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
